// File: rtl/mem_stage_ctrl_if.sv
// rtl/mem_stage_ctrl_if.sv - data memory request/ready bus between MEM stage controller and data memory
interface mem_stage_ctrl_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_be,
        output dmem_wdata,
        input  dmem_ready,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_be,
        input  dmem_wdata,
        output dmem_ready,
        output dmem_rdata
    );
endinterface

// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - RV32I MEM stage sequencer for a variable-latency data memory (optional MEM_TIMEOUT_EN)
module mem_stage_ctrl #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    MEM_cntl_MemRead,
    input  logic                    MEM_cntl_MemWrite,
    input  logic [2:0]              MEM_funct,
    input  logic [31:0]             MEM_ALUResult,
    input  logic [31:0]             MEM_WriteMemData,
    mem_stage_ctrl_if.master        dmem,
    output logic [31:0]             MEM_ReadData,
    output logic                    stall_mem,
    output logic                    wb_bubble,
    output logic                    misaligned,
    output logic                    bus_error
);

    if (TIMEOUT_CYCLES < 1 || (2 ** CNT_W) <= TIMEOUT_CYCLES) begin : gBadParams
        $error("mem_stage_ctrl: TIMEOUT_CYCLES must be >= 1 and below 2**CNT_W");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state;
    logic        access;
    logic        aligned;
    logic [3:0]  beNext;
    logic [31:0] wdataNext;
    logic [2:0]  latFunct;
    logic [1:0]  latLo;
    logic [31:0] readReg;

    // Select and extend the addressed byte/half/word of the returned memory word.
    function automatic logic [31:0] extractLoad(input logic [2:0] f, input logic [1:0] lo,
                                                input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        b = rd[7:0];
        case (lo)
            2'd1:    b = rd[15:8];
            2'd2:    b = rd[23:16];
            2'd3:    b = rd[31:24];
            default: b = rd[7:0];
        endcase
        h = lo[1] ? rd[31:16] : rd[15:0];
        case (f[1:0])
            2'b00:   extractLoad = f[2] ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   extractLoad = f[2] ? {16'd0, h} : {{16{h[15]}}, h};
            default: extractLoad = rd;
        endcase
    endfunction

    // Decode access, alignment, byte enables and lane-replicated store data; 011/110/111 fall into the word size.
    always_comb begin
        access    = MEM_cntl_MemRead | MEM_cntl_MemWrite;
        aligned   = 1'b1;
        beNext    = 4'b1111;
        wdataNext = MEM_WriteMemData;
        case (MEM_funct[1:0])
            2'b00: begin
                beNext    = 4'b0001 << MEM_ALUResult[1:0];
                wdataNext = {4{MEM_WriteMemData[7:0]}};
            end
            2'b01: begin
                aligned   = ~MEM_ALUResult[0];
                beNext    = MEM_ALUResult[1] ? 4'b1100 : 4'b0011;
                wdataNext = {2{MEM_WriteMemData[15:0]}};
            end
            default: begin
                aligned   = (MEM_ALUResult[1:0] == 2'b00);
            end
        endcase
    end

    // Stall and misalignment are decided in the same cycle the instruction sits in MEM.
    always_comb begin
        stall_mem    = ((state == IDLE) && access && aligned) || (state == BUSY);
        wb_bubble    = stall_mem;
        misaligned   = ~reset && (state == IDLE) && access && ~aligned;
        MEM_ReadData = misaligned ? 32'd0 : readReg;
    end

`ifdef MEM_TIMEOUT_EN
    logic [CNT_W-1:0] waitCnt;
    logic             busErr;

    assign bus_error = busErr;
`else
    assign bus_error = 1'b0;
`endif

    // Request sequencing: latch the access in IDLE, hold the request in BUSY, publish the result in DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            dmem.dmem_req   <= 1'b0;
            dmem.dmem_we    <= 1'b0;
            dmem.dmem_addr  <= 32'd0;
            dmem.dmem_be    <= 4'd0;
            dmem.dmem_wdata <= 32'd0;
            latFunct        <= 3'd0;
            latLo           <= 2'd0;
            readReg         <= 32'd0;
`ifdef MEM_TIMEOUT_EN
            waitCnt         <= '0;
            busErr          <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (access && aligned) begin
                        dmem.dmem_req   <= 1'b1;
                        dmem.dmem_we    <= MEM_cntl_MemWrite;
                        dmem.dmem_addr  <= {MEM_ALUResult[31:2], 2'b00};
                        dmem.dmem_be    <= beNext;
                        dmem.dmem_wdata <= wdataNext;
                        latFunct        <= MEM_funct;
                        latLo           <= MEM_ALUResult[1:0];
`ifdef MEM_TIMEOUT_EN
                        waitCnt         <= '0;
`endif
                        state           <= BUSY;
                    end else if (access) begin
                        readReg <= 32'd0;
                    end
                end
                BUSY: begin
                    if (dmem.dmem_ready) begin
                        dmem.dmem_req <= 1'b0;
                        readReg       <= dmem.dmem_we ? 32'd0
                                                      : extractLoad(latFunct, latLo, dmem.dmem_rdata);
                        state         <= DONE;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (waitCnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        dmem.dmem_req <= 1'b0;
                        readReg       <= 32'd0;
                        busErr        <= 1'b1;
                        state         <= DONE;
                    end else begin
                        waitCnt <= waitCnt + 1'b1;
                    end
`endif
                end
                DONE: begin
`ifdef MEM_TIMEOUT_EN
                    busErr <= 1'b0;
`endif
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb/tb_mem_stage_ctrl.sv - randomized scoreboard bench for mem_stage_ctrl
module tb_mem_stage_ctrl;

    localparam int TO = 4;
    localparam int KIND_NORM  = 0;
    localparam int KIND_MIS   = 1;
    localparam int KIND_ABORT = 2;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] rd;
        logic        berr;
        int          busy;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        memRead = 1'b0;
    logic        memWrite = 1'b0;
    logic [2:0]  funct = 3'd0;
    logic [31:0] aluResult = 32'd0;
    logic [31:0] writeData = 32'd0;
    logic [31:0] readData;
    logic        stallMem;
    logic        wbBubble;
    logic        misalignedOut;
    logic        busErrorOut;

    int checks = 0;
    int failures = 0;
    bit monOn = 1'b0;
    exp_t expQ[$];

    mem_stage_ctrl_if dmemIf();

    mem_stage_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
        .clk              (clk),
        .reset            (reset),
        .MEM_cntl_MemRead (memRead),
        .MEM_cntl_MemWrite(memWrite),
        .MEM_funct        (funct),
        .MEM_ALUResult    (aluResult),
        .MEM_WriteMemData (writeData),
        .dmem             (dmemIf),
        .MEM_ReadData     (readData),
        .stall_mem        (stallMem),
        .wb_bubble        (wbBubble),
        .misaligned       (misalignedOut),
        .bus_error        (busErrorOut)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference: size from funct, lanes from address offset, extension by arithmetic on the shifted word.
    function automatic exp_t model(input logic wr, input logic [2:0] f, input logic [31:0] a,
                                   input logic [31:0] d, input logic [31:0] rdata, input int waits);
        exp_t e;
        int size;
        int off;
        logic [63:0] v;
        size = (f[1:0] == 2'b00) ? 1 : (f[1:0] == 2'b01) ? 2 : 4;
        off = int'(a[1:0]);
        e.kind = (int'(a % size) != 0) ? KIND_MIS : KIND_NORM;
        e.addr = a & 32'hFFFF_FFFC;
        e.we = wr;
        e.be = 4'(((size == 1) ? 1 : (size == 2) ? 3 : 15) << off);
        for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = d[8*(i % size) +: 8];
        v = (64'(rdata) >> (8 * off)) & ((64'd1 << (8 * size)) - 64'd1);
        if (!f[2] && size < 4 && v[8*size-1]) v = v - (64'd1 << (8 * size));
        e.rd = wr ? 32'd0 : v[31:0];
        e.berr = 1'b0;
        e.busy = waits + 1;
`ifdef MEM_TIMEOUT_EN
        if (waits >= TO) begin
            e.busy = TO;
            e.berr = 1'b1;
            e.rd = 32'd0;
        end
`endif
        if (e.kind == KIND_MIS) e.rd = 32'd0;
        return e;
    endfunction

    // Issue one MEM-stage instruction and play the memory side with the given wait count.
    task automatic doAccess(input logic rd, input logic wr, input logic [2:0] f, input logic [31:0] a,
                            input logic [31:0] d, input logic [31:0] rdata, input int waits);
        exp_t e;
        @(posedge clk); #1;
        memRead = rd; memWrite = wr; funct = f; aluResult = a; writeData = d;
        dmemIf.dmem_ready = 1'($urandom_range(0, 1));
        dmemIf.dmem_rdata = $urandom;
        e = model(wr, f, a, d, rdata, waits);
        expQ.push_back(e);
        @(posedge clk); #1;
        if (e.kind == KIND_MIS) begin
            memRead = 1'b0; memWrite = 1'b0;
            return;
        end
        for (int i = 0; i < e.busy; i++) begin
            dmemIf.dmem_ready = (i == waits);
            dmemIf.dmem_rdata = (i == waits) ? rdata : $urandom;
            @(posedge clk); #1;
        end
        memRead = 1'b0; memWrite = 1'b0;
        dmemIf.dmem_ready = 1'($urandom_range(0, 1));
        dmemIf.dmem_rdata = $urandom;
    endtask

    // Load abandoned by a reset in its second BUSY cycle, followed by a stray ready pulse.
    task automatic doResetAbort();
        exp_t e;
        @(posedge clk); #1;
        memRead = 1'b1; memWrite = 1'b0; funct = 3'b010; aluResult = 32'h0000_3008;
        dmemIf.dmem_ready = 1'b0;
        e = model(1'b0, 3'b010, 32'h0000_3008, 32'd0, 32'd0, 5);
        e.kind = KIND_ABORT;
        e.busy = 2;
        expQ.push_back(e);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1; memRead = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        dmemIf.dmem_ready = 1'b1; dmemIf.dmem_rdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        dmemIf.dmem_ready = 1'b0;
    endtask

    // Monitor: matches DUT bus activity, misaligned pulses and DONE results against the queue.
    logic  prevReq = 1'b0;
    int    busyCnt = 0;
    int    stallRun = 0;
    logic [31:0] heldRd = 32'd0;
    exp_t  cur;

    always @(negedge clk) begin
        if (monOn) begin
            if (misalignedOut) begin
                if (expQ.size() == 0) begin
                    chk("unexpected_misaligned", 32'd1, 32'd0);
                end else begin
                    cur = expQ.pop_front();
                    chk("mis_kind", 32'(cur.kind), 32'(KIND_MIS));
                    chk("mis_req", 32'(dmemIf.dmem_req), 32'd0);
                    chk("mis_stall", 32'(stallMem), 32'd0);
                    chk("mis_rdata", readData, 32'd0);
                end
                heldRd = 32'd0;
                stallRun = 0;
            end else if (dmemIf.dmem_req && !prevReq) begin
                if (expQ.size() == 0) begin
                    chk("unexpected_req", 32'd1, 32'd0);
                end else begin
                    cur = expQ.pop_front();
                    chk("req_kind_normal", 32'(cur.kind == KIND_MIS), 32'd0);
                    chk("req_addr", dmemIf.dmem_addr, cur.addr);
                    chk("req_be", 32'(dmemIf.dmem_be), 32'(cur.be));
                    chk("req_we", 32'(dmemIf.dmem_we), 32'(cur.we));
                    if (cur.we) chk("req_wdata", dmemIf.dmem_wdata, cur.wdata);
                end
                busyCnt = 1;
            end else if (dmemIf.dmem_req) begin
                busyCnt++;
                chk("hold_addr", dmemIf.dmem_addr, cur.addr);
                chk("hold_be", 32'(dmemIf.dmem_be), 32'(cur.be));
                chk("hold_rdata", readData, heldRd);
            end else if (prevReq) begin
                chk("done_busy_cycles", 32'(busyCnt), 32'(cur.busy));
                chk("done_stall", 32'(stallMem), 32'd0);
                if (cur.kind == KIND_ABORT) begin
                    chk("abort_rdata", readData, 32'd0);
                    heldRd = 32'd0;
                end else begin
                    chk("done_rdata", readData, cur.rd);
                    chk("done_bus_error", 32'(busErrorOut), 32'(cur.berr));
                    chk("stall_cycles", 32'(stallRun), 32'(cur.busy + 1));
                    heldRd = cur.rd;
                end
                stallRun = 0;
            end else begin
                chk("idle_hold_rdata", readData, heldRd);
                chk("idle_bus_error", 32'(busErrorOut), 32'd0);
            end
            chk("wb_bubble", 32'(wbBubble), 32'(stallMem));
            if (stallMem) stallRun++;
        end
        prevReq = dmemIf.dmem_req;
    end

    initial begin
        logic [2:0] fSel [8];
        logic [2:0] f;
        logic       rd;
        logic       wr;
        logic [31:0] a;
        fSel = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
        dmemIf.dmem_ready = 1'b0;
        dmemIf.dmem_rdata = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_req", 32'(dmemIf.dmem_req), 32'd0);
        chk("reset_we", 32'(dmemIf.dmem_we), 32'd0);
        chk("reset_addr", dmemIf.dmem_addr, 32'd0);
        chk("reset_be", 32'(dmemIf.dmem_be), 32'd0);
        chk("reset_wdata", dmemIf.dmem_wdata, 32'd0);
        chk("reset_rdata", readData, 32'd0);
        chk("reset_stall", 32'(stallMem), 32'd0);
        chk("reset_misaligned", 32'(misalignedOut), 32'd0);
        chk("reset_bus_error", 32'(busErrorOut), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        monOn = 1'b1;

        doAccess(1'b1, 1'b0, 3'b010, 32'h0000_1004, 32'd0, 32'hDEAD_BEEF, 0);
        doAccess(1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'd0, 32'h80FF_FF7F, 0);
        doAccess(1'b1, 1'b0, 3'b100, 32'h0000_1003, 32'd0, 32'h80FF_FF7F, 1);
        doAccess(1'b1, 1'b0, 3'b101, 32'h0000_1002, 32'd0, 32'h80FF_FF7F, 0);
        doAccess(1'b0, 1'b1, 3'b000, 32'h0000_2001, 32'h1234_56AB, 32'h5555_5555, 3);
        doAccess(1'b0, 1'b1, 3'b001, 32'h0000_2003, 32'hAAAA_BBBB, 32'd0, 0);
        doAccess(1'b1, 1'b0, 3'b010, 32'h0000_2002, 32'd0, 32'd0, 0);
        doAccess(1'b1, 1'b1, 3'b000, 32'h0000_2003, 32'h0000_00C3, 32'hFFFF_FFFF, 2);
        doResetAbort();
`ifdef MEM_TIMEOUT_EN
        doAccess(1'b1, 1'b0, 3'b010, 32'h0000_4000, 32'd0, 32'h1111_2222, TO + 3);
        doAccess(1'b1, 1'b0, 3'b010, 32'h0000_4004, 32'd0, 32'h3333_4444, TO - 1);
`endif

        for (int n = 0; n < 300; n++) begin
            f = fSel[$urandom_range(0, 7)];
            a = {16'h0000, 16'($urandom)};
            case ($urandom_range(0, 5))
                0:       begin rd = 1'b0; wr = 1'b0; end
                1, 2:    begin rd = 1'b0; wr = 1'b1; end
                3:       begin rd = 1'b1; wr = 1'b1; end
                default: begin rd = 1'b1; wr = 1'b0; end
            endcase
            if (!rd && !wr) begin
                @(posedge clk); #1;
                funct = f; aluResult = a; writeData = $urandom;
                dmemIf.dmem_ready = 1'($urandom_range(0, 1));
                dmemIf.dmem_rdata = $urandom;
            end else begin
                doAccess(rd, wr, f, a, $urandom, $urandom,
                         ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, TO + 2))
                                                     : int'($urandom_range(0, 2)));
            end
        end

        repeat (4) @(posedge clk);
        #1;
        chk("queue_drained", 32'(expQ.size()), 32'd0);
        chk("final_req_idle", 32'(dmemIf.dmem_req), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
